// File: rtl/mem_d_result_port.sv
// Test-result buffer, 64-bit cycle/instret counters and exit-code latch
// answering on the core's data-memory port with a fixed one-cycle response.
module mem_d_result_port #(
  parameter int NUM_RESULTS = 12,
  parameter int ADDR_W      = 9
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] mem_d_addr_i,
  input  logic [31:0] mem_d_data_wr_i,
  input  logic        mem_d_rd_i,
  input  logic [3:0]  mem_d_wr_i,
  input  logic        mem_d_cacheable_i,
  input  logic [10:0] mem_d_req_tag_i,
  input  logic        mem_d_invalidate_i,
  input  logic        mem_d_writeback_i,
  input  logic        mem_d_flush_i,
  input  logic [1:0]  retire_i,
  output logic [31:0] mem_d_data_rd_o,
  output logic        mem_d_accept_o,
  output logic        mem_d_ack_o,
  output logic        mem_d_error_o,
  output logic [10:0] mem_d_resp_tag_o,
  output logic        done_o,
  output logic        pass_o,
  output logic [31:0] exit_code_o
);

  localparam int IDX_W = (NUM_RESULTS > 1) ? $clog2(NUM_RESULTS) : 1;
  localparam logic [ADDR_W-1:0] OFF_RES_END = ADDR_W'(4 * NUM_RESULTS);
  localparam logic [ADDR_W-1:0] OFF_CTRL    = ADDR_W'(12'h100);
  localparam logic [ADDR_W-1:0] OFF_CYC_LO  = ADDR_W'(12'h104);
  localparam logic [ADDR_W-1:0] OFF_CYC_HI  = ADDR_W'(12'h108);
  localparam logic [ADDR_W-1:0] OFF_INS_LO  = ADDR_W'(12'h10C);
  localparam logic [ADDR_W-1:0] OFF_INS_HI  = ADDR_W'(12'h110);
  localparam logic [ADDR_W-1:0] OFF_EXIT    = ADDR_W'(12'h114);

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_w;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[b*8 +: 8] = new_w[b*8 +: 8];
    end
    return res;
  endfunction

  function automatic logic [63:0] retire_count(input logic [1:0] ret);
    return 64'(ret[0]) + 64'(ret[1]);
  endfunction

  logic [31:0] r_result [NUM_RESULTS];
  logic [63:0] r_cycle;
  logic [63:0] r_instret;
  logic [31:0] r_cyc_shadow;
  logic [31:0] r_ins_shadow;
  logic        r_en;
  logic        r_done;
  logic        r_pass;
  logic [31:0] r_exit;
  logic        r_vld_p1;
  logic        r_err_p1;
  logic [31:0] r_rdata_p1;
  logic [10:0] r_tag_p1;

  logic [ADDR_W-1:0] w_off;
  logic [IDX_W-1:0]  w_idx;
  logic        w_maint, w_req, w_xfer, w_aligned, w_hit, w_err, w_act;
  logic        w_do_rd, w_do_wr, w_ctrl_wr, w_clr;
  logic        w_sel_res, w_sel_ctrl, w_sel_cyc_lo, w_sel_cyc_hi;
  logic        w_sel_ins_lo, w_sel_ins_hi, w_sel_exit;
  logic [31:0] w_rdata;
  logic        w_unused;

  assign w_unused = ^{mem_d_cacheable_i, mem_d_addr_i[31:ADDR_W]};

  assign w_off        = mem_d_addr_i[ADDR_W-1:0];
  assign w_idx        = w_off[IDX_W+1:2];
  assign w_maint      = mem_d_invalidate_i | mem_d_writeback_i | mem_d_flush_i;
  assign w_req        = mem_d_rd_i | (|mem_d_wr_i) | w_maint;
  assign w_xfer       = w_req & rst_i;
  assign w_aligned    = (w_off[1:0] == 2'b00);
  assign w_sel_res    = w_aligned && (w_off < OFF_RES_END);
  assign w_sel_ctrl   = (w_off == OFF_CTRL);
  assign w_sel_cyc_lo = (w_off == OFF_CYC_LO);
  assign w_sel_cyc_hi = (w_off == OFF_CYC_HI);
  assign w_sel_ins_lo = (w_off == OFF_INS_LO);
  assign w_sel_ins_hi = (w_off == OFF_INS_HI);
  assign w_sel_exit   = (w_off == OFF_EXIT);
  assign w_hit        = w_sel_res | w_sel_ctrl | w_sel_cyc_lo | w_sel_cyc_hi |
                        w_sel_ins_lo | w_sel_ins_hi | w_sel_exit;

  // Maintenance wins over rd/wr: it is answered cleanly and touches nothing.
  assign w_err     = !w_maint && !w_hit;
  assign w_act     = w_xfer && !w_maint && w_hit;
  assign w_do_rd   = w_act && mem_d_rd_i;
  assign w_do_wr   = w_act && (|mem_d_wr_i);
  assign w_ctrl_wr = w_do_wr && w_sel_ctrl && !r_done;
  assign w_clr     = w_ctrl_wr && mem_d_data_wr_i[0];

  always_comb begin
    w_rdata = '0;
    if (!w_maint) begin
      if (w_sel_res)         w_rdata = r_result[w_idx];
      else if (w_sel_cyc_lo) w_rdata = r_cycle[31:0];
      else if (w_sel_cyc_hi) w_rdata = r_cyc_shadow;
      else if (w_sel_ins_lo) w_rdata = r_instret[31:0];
      else if (w_sel_ins_hi) w_rdata = r_ins_shadow;
    end
  end

  // ---- p0 -> p1: request stage into response register ----
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_vld_p1   <= 1'b0;
      r_err_p1   <= 1'b0;
      r_rdata_p1 <= '0;
      r_tag_p1   <= '0;
    end else begin
      r_vld_p1 <= w_xfer;
      if (w_xfer) begin
        r_err_p1   <= w_err;
        r_rdata_p1 <= w_err ? 32'd0 : w_rdata;
        r_tag_p1   <= mem_d_req_tag_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      for (int i = 0; i < NUM_RESULTS; i++) r_result[i] <= '0;
    end else if (w_do_wr && w_sel_res) begin
      r_result[w_idx] <= merge_bytes(r_result[w_idx], mem_d_data_wr_i, mem_d_wr_i);
    end
  end

  // Increment uses the enable/done held this cycle, so an EXIT or CTRL
  // write only affects counting from the following cycle.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_en         <= 1'b1;
      r_cycle      <= '0;
      r_instret    <= '0;
      r_cyc_shadow <= '0;
      r_ins_shadow <= '0;
    end else begin
      if (w_ctrl_wr) r_en <= mem_d_data_wr_i[1];
      if (w_clr) begin
        r_cycle   <= '0;
        r_instret <= '0;
      end else if (r_en && !r_done) begin
        r_cycle   <= r_cycle + 64'd1;
        r_instret <= r_instret + retire_count(retire_i);
      end
      if (w_do_rd && w_sel_cyc_lo) r_cyc_shadow <= r_cycle[63:32];
      if (w_do_rd && w_sel_ins_lo) r_ins_shadow <= r_instret[63:32];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_done <= 1'b0;
      r_pass <= 1'b0;
      r_exit <= '0;
    end else if (w_do_wr && w_sel_exit && !r_done) begin
      r_done <= 1'b1;
      r_pass <= (mem_d_data_wr_i == 32'd0);
      r_exit <= mem_d_data_wr_i;
    end
  end

  // Gating with reset drops a response whose cycle coincides with reset.
  assign mem_d_accept_o   = rst_i;
  assign mem_d_ack_o      = r_vld_p1 & rst_i;
  assign mem_d_error_o    = r_err_p1 & rst_i;
  assign mem_d_data_rd_o  = r_rdata_p1;
  assign mem_d_resp_tag_o = r_tag_p1;
  assign done_o           = r_done;
  assign pass_o           = r_pass;
  assign exit_code_o      = r_exit;

endmodule

// File: tb/tb_mem_d_result_port.sv
// Scoreboard bench for mem_d_result_port: a register-map level model predicts
// every response; a negedge monitor matches acks against the expectation queue.
module tb_mem_d_result_port;
  localparam int NR = 12;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] addr, wdata;
  logic        rd, cacheable, inv, wb, fl;
  logic [3:0]  wr;
  logic [10:0] tag;
  logic [1:0]  ret;
  logic [31:0] rdata, exit_code;
  logic        accept, ack, err, done, pass;
  logic [10:0] rtag;

  always #5 clk = ~clk;

  mem_d_result_port #(.NUM_RESULTS(NR), .ADDR_W(9)) dut (
    .clk_i(clk), .rst_i(rst_n),
    .mem_d_addr_i(addr), .mem_d_data_wr_i(wdata), .mem_d_rd_i(rd),
    .mem_d_wr_i(wr), .mem_d_cacheable_i(cacheable), .mem_d_req_tag_i(tag),
    .mem_d_invalidate_i(inv), .mem_d_writeback_i(wb), .mem_d_flush_i(fl),
    .retire_i(ret),
    .mem_d_data_rd_o(rdata), .mem_d_accept_o(accept), .mem_d_ack_o(ack),
    .mem_d_error_o(err), .mem_d_resp_tag_o(rtag),
    .done_o(done), .pass_o(pass), .exit_code_o(exit_code)
  );

  typedef struct {
    logic [31:0] data;
    logic        err;
    logic [10:0] tag;
    int          due;
  } exp_t;
  exp_t q[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference state: the register map as software sees it.
  logic [31:0] m_res [NR];
  logic [63:0] m_cyc, m_ins;
  logic [31:0] m_cs, m_is, m_exit;
  logic        m_en, m_done, m_pass;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ack) begin
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_ack cyc=%0d tag=%0h data=%08h", cyc, rtag, rdata);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (e.due != cyc || rdata !== e.data || err !== e.err || rtag !== e.tag) begin
          failures++;
          $display("FAIL response cyc=%0d got data=%08h err=%0b tag=%0h; want cyc=%0d data=%08h err=%0b tag=%0h",
                   cyc, rdata, err, rtag, e.due, e.data, e.err, e.tag);
        end
      end
    end else if (q.size() > 0 && q[0].due <= cyc) begin
      checks++;
      failures++;
      $display("FAIL missing_ack cyc=%0d want tag=%0h", cyc, q[0].tag);
      void'(q.pop_front());
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of stimulus, predict its response, advance the model.
  task automatic step(input logic rd_v, input logic [3:0] wr_v, input logic [31:0] a,
                      input logic [31:0] d, input logic [10:0] t, input logic [1:0] r,
                      input logic [2:0] mt);
    logic [8:0]  off;
    logic        hit, e_err, clr, live;
    logic [31:0] rv;
    int          k;
    exp_t        e;
    rd = rd_v; wr = wr_v; addr = a; wdata = d; tag = t; ret = r;
    inv = mt[0]; wb = mt[1]; fl = mt[2]; cacheable = $urandom_range(0, 1);
    if (!rst_n) begin
      for (int i = 0; i < NR; i++) m_res[i] = '0;
      m_cyc = '0; m_ins = '0; m_cs = '0; m_is = '0;
      m_en = 1'b1; m_done = 1'b0; m_pass = 1'b0; m_exit = '0;
      q.delete();
    end else begin
      off = a[8:0];
      hit = 1'b0; rv = '0; clr = 1'b0;
      live = m_en && !m_done;
      if (rd_v || wr_v != 4'd0 || mt != 3'd0) begin
        if (mt == 3'd0) begin
          if (off[1:0] == 2'd0 && int'(off) < 4 * NR) begin
            hit = 1'b1; k = int'(off) / 4; rv = m_res[k];
          end else begin
            case (off)
              9'h100, 9'h114: hit = 1'b1;
              9'h104: begin hit = 1'b1; rv = m_cyc[31:0]; end
              9'h108: begin hit = 1'b1; rv = m_cs; end
              9'h10C: begin hit = 1'b1; rv = m_ins[31:0]; end
              9'h110: begin hit = 1'b1; rv = m_is; end
              default: hit = 1'b0;
            endcase
          end
        end
        e_err = (mt == 3'd0) && !hit;
        e.data = e_err ? 32'd0 : rv; e.err = e_err; e.tag = t; e.due = cyc + 1;
        q.push_back(e);
        if (hit) begin
          if (rd_v && off == 9'h104) m_cs = m_cyc[63:32];
          if (rd_v && off == 9'h10C) m_is = m_ins[63:32];
          if (wr_v != 4'd0) begin
            if (int'(off) < 4 * NR) begin
              k = int'(off) / 4;
              for (int b = 0; b < 4; b++) if (wr_v[b]) m_res[k][8*b +: 8] = d[8*b +: 8];
            end else if (off == 9'h100 && !m_done) begin
              clr = d[0]; m_en = d[1];
            end else if (off == 9'h114 && !m_done) begin
              m_done = 1'b1; m_pass = (d == 32'd0); m_exit = d;
            end
          end
        end
      end
      if (clr) begin
        m_cyc = '0; m_ins = '0;
      end else if (live) begin
        m_cyc = m_cyc + 64'd1;
        m_ins = m_ins + 64'(r[0]) + 64'(r[1]);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'd0, 32'd0, 32'd0, 11'd0, 2'd0, 3'd0);
  endtask

  task automatic wr32(input logic [31:0] a, input logic [31:0] d, input logic [10:0] t);
    step(1'b0, 4'hF, a, d, t, 2'd0, 3'd0);
  endtask

  task automatic rd32(input logic [31:0] a, input logic [10:0] t);
    step(1'b1, 4'd0, a, 32'd0, t, 2'd0, 3'd0);
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    idle(n);
    rst_n = 1'b1;
  endtask

  task automatic random_op();
    logic [31:0] a, d;
    logic [8:0]  off;
    logic [3:0]  w;
    logic        r;
    logic [2:0]  mt;
    a = $urandom & 32'hFFFF_FE00;
    d = $urandom;
    r = $urandom_range(0, 1);
    w = 4'($urandom_range(0, 15));
    mt = 3'd0;
    case ($urandom_range(0, 9))
      0, 1, 2, 3: begin
        off = 9'(4 * $urandom_range(0, 15));
        if (!r && w == 4'd0) r = 1'b1;
      end
      4: begin off = 9'(9'h104 + 4 * $urandom_range(0, 3)); r = 1'b1; w = 4'd0; end
      5: begin off = 9'(9'h104 + 4 * $urandom_range(0, 3)); w = 4'hF; end
      6: begin
        off = 9'h100; r = 1'b0;
        w = ($urandom_range(0, 3) == 0) ? 4'hF : 4'd0;
        d = {30'd0, 1'b1, ($urandom_range(0, 7) == 0)};
        if ($urandom_range(0, 5) == 0) d[1] = 1'b0;
      end
      7: begin off = 9'($urandom_range(9'h118, 9'h1FF)) | 9'($urandom_range(0, 1)); r = 1'b1; end
      8: begin off = 9'($urandom_range(0, 511)); mt = 3'(1 << $urandom_range(0, 2)); r = 1'b0; w = 4'd0; end
      default: begin off = 9'd0; r = 1'b0; w = 4'd0; end
    endcase
    a[8:0] = off;
    step(r, w, a, d, 11'($urandom), 2'($urandom_range(0, 3)), mt);
  endtask

  initial begin
    rst_n = 1'b0;
    do_reset(3);
    rst_n = 1'b0;
    chk("reset_ack", {63'd0, ack}, 64'd0);
    chk("reset_err", {63'd0, err}, 64'd0);
    chk("reset_rdata", {32'd0, rdata}, 64'd0);
    chk("reset_tag", {53'd0, rtag}, 64'd0);
    chk("reset_done_pass", {62'd0, done, pass}, 64'd0);
    chk("reset_exit", {32'd0, exit_code}, 64'd0);
    chk("reset_accept", {63'd0, accept}, 64'd0);
    rst_n = 1'b1;
    #1;
    chk("accept_after_reset", {63'd0, accept}, 64'd1);
    idle(9);
    rd32(32'h104, 11'h001);

    wr32(32'h24, 32'h0000_00FF, 11'h002);
    rd32(32'h24, 11'h3A5);
    wr32(32'h8, 32'h1122_3344, 11'h003);
    step(1'b0, 4'b0010, 32'h8, 32'h0000_AB00, 11'h004, 2'd0, 3'd0);
    rd32(32'h8, 11'h005);
    step(1'b1, 4'hF, 32'h8, 32'hDEAD_BEEF, 11'h006, 2'd0, 3'd0);
    rd32(32'h8, 11'h007);

    for (int i = 0; i < 5; i++) step(1'b0, 4'd0, 32'd0, 32'd0, 11'd0, 2'b11, 3'd0);
    for (int i = 0; i < 3; i++) step(1'b0, 4'd0, 32'd0, 32'd0, 11'd0, 2'b01, 3'd0);
    rd32(32'h10C, 11'h008);
    step(1'b0, 4'hF, 32'h100, 32'h3, 11'h009, 2'b11, 3'd0);
    rd32(32'h10C, 11'h00A);
    rd32(32'h110, 11'h00B);

    for (int i = 0; i < 400; i++) random_op();
    wr32(32'h100, 32'h2, 11'h00C);

    wr32(32'h100, 32'h0, 11'h00D);
    force dut.r_cycle = 64'h0000_0000_FFFF_FFFF;
    idle(1);
    release dut.r_cycle;
    m_cyc = 64'h0000_0000_FFFF_FFFF;
    wr32(32'h100, 32'h2, 11'h00E);
    idle(1);
    rd32(32'h104, 11'h00F);
    rd32(32'h108, 11'h010);
    chk("shadow_model", m_cs, 64'h1);

    rd32(32'h1F0, 11'h011);
    rd32(32'h002, 11'h012);
    step(1'b0, 4'hF, 32'h104, 32'h1234_5678, 11'h013, 2'd0, 3'd0);
    step(1'b0, 4'd0, 32'h24, 32'd0, 11'h014, 2'd0, 3'b010);
    for (int t = 1; t <= 4; t++) rd32(32'h24, 11'(t));
    rd32(32'h24, 11'h007);
    rst_n = 1'b0;
    #1;
    chk("ack_during_reset", {63'd0, ack}, 64'd0);
    idle(1);
    rst_n = 1'b1;
    idle(2);

    wr32(32'h114, 32'h0, 11'h020);
    chk("exit0_done", {63'd0, done}, 64'd1);
    chk("exit0_pass", {63'd0, pass}, 64'd1);
    rd32(32'h104, 11'h021);
    idle(3);
    rd32(32'h104, 11'h022);
    wr32(32'h114, 32'h5, 11'h023);
    chk("exit_ignored_code", {32'd0, exit_code}, 64'd0);
    chk("exit_ignored_done", {63'd0, done}, 64'd1);
    wr32(32'h100, 32'h1, 11'h024);
    rd32(32'h10C, 11'h025);

    do_reset(1);
    wr32(32'h114, 32'h5, 11'h030);
    chk("exit5_pass", {63'd0, pass}, 64'd0);
    chk("exit5_code", {32'd0, exit_code}, 64'd5);
    chk("exit5_done", {63'd0, done}, 64'd1);

    idle(3);
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
